// File: rtl/program_counter_ras.sv
// program_counter_ras: fetch PC with jump/call/return/branch redirects; return-address stack built only when PC_RAS_EN is defined
module program_counter_ras #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int STRIDE = 4,
  parameter int RAS_DEPTH = 8,
  localparam int CW = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             jump_i,
  input  logic             call_i,
  input  logic             return_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic [WIDTH-1:0] offset_i,
  output logic [WIDTH-1:0] pc_current_o,
  output logic [CW-1:0]    ras_count_o,
  output logic             ras_overflow_o,
  output logic             ras_underflow_o
);
  logic [WIDTH-1:0] pc_q, pc_seq, pc_next;
  assign pc_seq = pc_q + WIDTH'(STRIDE);
  assign pc_current_o = pc_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) pc_q <= RESET_VECTOR;
    else if (enable_i) pc_q <= pc_next;
`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0] wp_q, wp_top;
  logic [CW-1:0] count_q;
  logic do_call, do_ret, empty, full, ovf_q, unf_q;
  always_comb begin
    do_call = !jump_i && call_i;
    do_ret = !jump_i && !call_i && return_i;
    empty = count_q == '0;
    full = count_q == CW'(RAS_DEPTH);
    wp_top = wp_q - PW'(1);
    pc_next = (jump_i || call_i) ? target_i :
              do_ret ? (empty ? pc_seq : ras_q[wp_top]) :
              branch_i ? pc_q + offset_i : pc_seq;
  end
  // a push onto a full stack overwrites the oldest slot, which is exactly where wp_q points
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (enable_i) begin
      ovf_q <= do_call && full;
      unf_q <= do_ret && empty;
      if (do_call) begin
        wp_q <= wp_q + PW'(1);
        if (!full) count_q <= count_q + CW'(1);
      end else if (do_ret && !empty) begin
        wp_q <= wp_top;
        count_q <= count_q - CW'(1);
      end
    end else begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end
  always_ff @(posedge clk_i)
    if (enable_i && do_call) ras_q[wp_q] <= pc_seq;
  assign ras_count_o = count_q;
  assign ras_overflow_o = ovf_q;
  assign ras_underflow_o = unf_q;
`else
  assign pc_next = (jump_i || call_i) ? target_i :
                   (!return_i && branch_i) ? pc_q + offset_i : pc_seq;
  assign ras_count_o = '0;
  assign ras_overflow_o = 1'b0;
  assign ras_underflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_program_counter_ras.sv
// tb_program_counter_ras: directed plus random stimulus against a queue-based reference model
module tb_program_counter_ras;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, j = 1'b0, c = 1'b0, r = 1'b0, b = 1'b0;
  logic [31:0] tgt = '0, off = '0, pc;
  logic [2:0] cnt;
  logic ovf, unf;
  int errors = 0, checks = 0;
  logic [31:0] m_pc;
  logic m_ovf, m_unf;
  logic [31:0] stk[$];

  program_counter_ras #(.WIDTH(32), .RESET_VECTOR(32'h100), .STRIDE(4), .RAS_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .jump_i(j), .call_i(c), .return_i(r),
    .branch_i(b), .target_i(tgt), .offset_i(off), .pc_current_o(pc), .ras_count_o(cnt),
    .ras_overflow_o(ovf), .ras_underflow_o(unf));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".cnt"}, 32'(cnt), 32'(stk.size()));
    check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, ".unf"}, 32'(unf), 32'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = 32'h100;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    stk.delete();
  endtask

  task automatic model_step();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (!en) return;
    if (j) m_pc = tgt;
    else if (c) begin
`ifdef PC_RAS_EN
      if (stk.size() == DEPTH) begin
        void'(stk.pop_front());
        m_ovf = 1'b1;
      end
      stk.push_back(seq);
`endif
      m_pc = tgt;
    end else if (r) begin
`ifdef PC_RAS_EN
      if (stk.size() > 0) m_pc = stk.pop_back();
      else begin
        m_pc = seq;
        m_unf = 1'b1;
      end
`else
      m_pc = seq;
`endif
    end else if (b) m_pc = m_pc + off;
    else m_pc = seq;
  endtask

  task automatic step(input string tag, input logic e, input logic [3:0] req,
                      input logic [31:0] t, input logic [31:0] o);
    en = e;
    {j, c, r, b} = req;
    tgt = t;
    off = o;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    check("reset.pc_const", pc, 32'h100);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("idle", 1'b1, 4'b0000, '0, '0);
    check("idle.pc_const", pc, 32'h10C);
    for (int i = 0; i < 2; i++) step("hold", 1'b0, 4'b1111, 32'h0, 32'h0);
    check("hold.pc_const", pc, 32'h10C);
    step("branch_back", 1'b1, 4'b0001, '0, 32'hFFFF_FFF8);
    check("branch_back.pc_const", pc, 32'h104);
    step("jump_top", 1'b1, 4'b1000, 32'hFFFF_FFFC, '0);
    step("wrap", 1'b1, 4'b0000, '0, '0);
    check("wrap.pc_const", pc, 32'h0);
    step("jump_200", 1'b1, 4'b1000, 32'h200, '0);
    step("call_400", 1'b1, 4'b0100, 32'h400, '0);
    step("seq_404", 1'b1, 4'b0000, '0, '0);
    step("ret", 1'b1, 4'b0010, '0, '0);
    step("jump_10", 1'b1, 4'b1000, 32'h10, '0);
    for (int i = 0; i < 5; i++) step("call_chain", 1'b1, 4'b0100, 32'(32'h20 + 32'h10 * i), '0);
    for (int i = 0; i < 5; i++) step("ret_chain", 1'b1, 4'b0010, '0, '0);
    step("call_a", 1'b1, 4'b0100, 32'h800, '0);
    step("jcr_combo", 1'b1, 4'b1110, 32'h900, '0);
    step("cr_combo", 1'b1, 4'b0110, 32'hA00, '0);
    step("call_b", 1'b1, 4'b0100, 32'hB00, '0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    check("async_reset.pc_const", pc, 32'h100);
    #2 rst_n = 1'b1;
    step("ret_after_reset", 1'b1, 4'b0010, '0, '0);
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
           $urandom & 32'hFFFF_FFFC, 32'($signed(10'($urandom)) * 4));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
